// File: rtl/panel_pkg.sv
// Shared geometry, enums and the cursor step function for the front-panel cursor controller.
package panel_pkg;
  localparam int ROW0_LEN     = 16;
  localparam int ROW1_LEN     = 9;
  localparam int ROW1_BASE    = 16;
  localparam int SWITCH_COUNT = ROW0_LEN + ROW1_LEN;

  typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

  typedef struct packed {
    logic [3:0] x;
    logic       row;
  } cursor_t;

  // One cursor move; x wraps within the current row, entering row 1 clamps x.
  function automatic cursor_t cursor_step(input cursor_t c, input dir_t d);
    cursor_t    n;
    logic [3:0] xmax;
    n    = c;
    xmax = c.row ? 4'(ROW1_LEN - 1) : 4'(ROW0_LEN - 1);
    case (d)
      DIR_UP, DIR_DOWN: begin
        n.row = ~c.row;
        if (!c.row && c.x > 4'(ROW1_LEN - 1)) n.x = 4'(ROW1_LEN - 1);
      end
      DIR_LEFT:  n.x = (c.x == 4'd0) ? xmax : c.x - 4'd1;
      DIR_RIGHT: n.x = (c.x >= xmax) ? 4'd0 : c.x + 4'd1;
      default: ;
    endcase
    return n;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// 2-FF synchroniser followed by a stable-count debouncer for one raw button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_db
);
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle where the input agrees with the debounced state restarts the count.
  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) db_d = sync2_q;
      else cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_db = db_q;
endmodule

// File: rtl/panel_cursor_ctrl.sv
// Front-panel cursor: debounced buttons drive a two-row switch cursor with auto-repeat
// and a stretched switch-throw action level.
module panel_cursor_ctrl
  import panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int REPEAT_DELAY      = 20000000,
  parameter int REPEAT_PERIOD     = 5000000,
  parameter int ACTION_MIN_CYCLES = 1000000,
  parameter int CNT_W             = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_action,
  output logic [3:0] cursor_index_x,
  output logic [4:0] cursor_index_y,
  output logic [4:0] cursor_index,
  output logic       cursor_action,
  output logic       move_pulse
);
  localparam int NUM_BTN = 5;

  logic [NUM_BTN-1:0] btn_raw, btn_db;
  assign btn_raw = {btn_action, btn_right, btn_left, btn_down, btn_up};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
      .clk    (clk),
      .rst    (reset),
      .btn_in (btn_raw[i]),
      .btn_db (btn_db[i])
    );
  end

  rep_state_t       state_q, state_d;
  dir_t             dir_q, dir_d, pick;
  logic [CNT_W-1:0] cnt_q, cnt_d, stretch_q, stretch_d;
  cursor_t          cur_q, cur_d;
  logic [4:0]       y_q, y_d, idx_q, idx_d;
  logic             move, held;
  logic             pulse_q, pulse_d;
  logic             act_q, act_d, act_prev_q, act_prev_d;

  always_comb begin
    if (btn_db[0])      pick = DIR_UP;
    else if (btn_db[1]) pick = DIR_DOWN;
    else if (btn_db[2]) pick = DIR_LEFT;
    else if (btn_db[3]) pick = DIR_RIGHT;
    else                pick = DIR_NONE;
    case (dir_q)
      DIR_UP:    held = btn_db[0];
      DIR_DOWN:  held = btn_db[1];
      DIR_LEFT:  held = btn_db[2];
      DIR_RIGHT: held = btn_db[3];
      default:   held = 1'b0;
    endcase
  end

  // Counters load N-1 so a move lands exactly N cycles after the previous one.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    move    = 1'b0;
    if (act_q) begin
      state_d = IDLE;
      dir_d   = DIR_NONE;
    end else begin
      case (state_q)
        IDLE: if (pick != DIR_NONE) begin
          dir_d   = pick;
          move    = 1'b1;
          cnt_d   = CNT_W'(REPEAT_DELAY - 1);
          state_d = DELAY;
        end
        DELAY, REPEAT: begin
          if (!held) begin
            state_d = IDLE;
            dir_d   = DIR_NONE;
          end else if (cnt_q == '0) begin
            move    = 1'b1;
            cnt_d   = CNT_W'(REPEAT_PERIOD - 1);
            state_d = REPEAT;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    cur_d   = move ? cursor_step(cur_q, dir_d) : cur_q;
    y_d     = cur_d.row ? 5'(ROW1_BASE) : 5'd0;
    idx_d   = y_d + {1'b0, cur_d.x};
    pulse_d = move;
  end

  // Action level: set on debounced press, held until both released and stretch expired.
  always_comb begin
    act_prev_d = btn_db[4];
    act_d      = act_q;
    stretch_d  = stretch_q;
    if (btn_db[4] && !act_prev_q) begin
      act_d     = 1'b1;
      stretch_d = CNT_W'(ACTION_MIN_CYCLES - 1);
    end else begin
      if (stretch_q != '0) stretch_d = stretch_q - CNT_W'(1);
      if (act_q && !btn_db[4] && stretch_q == '0) act_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      dir_q      <= DIR_NONE;
      cnt_q      <= '0;
      cur_q      <= '0;
      y_q        <= '0;
      idx_q      <= '0;
      pulse_q    <= 1'b0;
      act_q      <= 1'b0;
      act_prev_q <= 1'b0;
      stretch_q  <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      y_q        <= y_d;
      idx_q      <= idx_d;
      pulse_q    <= pulse_d;
      act_q      <= act_d;
      act_prev_q <= act_prev_d;
      stretch_q  <= stretch_d;
    end
  end

  assign cursor_index_x = cur_q.x;
  assign cursor_index_y = y_q;
  assign cursor_index   = idx_q;
  assign cursor_action  = act_q;
  assign move_pulse     = pulse_q;
endmodule
